// File: rtl/alu_sequencer.sv
// Fetch/decode/execute sequencer that feeds an external 8-bit ALU from a synchronous program ROM.
// Holds PC, opcode, accumulator and carry/zero flags, and drives a valid/ready output port.
module alu_sequencer #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] pm_addr,
   input  logic [7:0]        pm_data,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [2:0]        alu_sel,
   input  logic [7:0]        alu_result,
   input  logic              alu_carry,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        acc,
   output logic              carry_flag,
   output logic              zero_flag,
   output logic              halted
);

   typedef enum logic [2:0] {FETCH, DECODE, OPND, OUT, HALT} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] pc, pc_next, pc_inc, target;
   // Only the opcode nibble of the first byte is kept; the low nibble never affects behaviour.
   logic [3:0]        ir_op, ir_op_next;
   logic [7:0]        acc_next;
   logic              cf_next, zf_next;

   assign pc_inc    = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign target    = ADDR_W'(pm_data);
   assign pm_addr   = pc;
   assign alu_a     = acc;
   assign alu_b     = pm_data;
   assign alu_sel   = ir_op[2:0];
   assign out_data  = acc;
   assign out_valid = (state == OUT);
   assign halted    = (state == HALT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         ir_op      <= 4'h0;
         acc        <= 8'h00;
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         ir_op      <= ir_op_next;
         acc        <= acc_next;
         carry_flag <= cf_next;
         zero_flag  <= zf_next;
      end
   end

   // In DECODE the opcode is taken straight from pm_data because ir is only loaded at the end of that cycle.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      ir_op_next = ir_op;
      acc_next   = acc;
      cf_next    = carry_flag;
      zf_next    = zero_flag;
      case (state)
         FETCH: begin
            pc_next    = pc_inc;
            state_next = DECODE;
         end
         DECODE: begin
            ir_op_next = pm_data[7:4];
            case (pm_data[7:4])
               4'h8:             state_next = OUT;
               4'hC, 4'hD, 4'hE: state_next = FETCH;
               4'hF:             state_next = HALT;
               default: begin
                  pc_next    = pc_inc;
                  state_next = OPND;
               end
            endcase
         end
         OPND: begin
            state_next = FETCH;
            if (!ir_op[3]) begin
               acc_next = alu_result;
               cf_next  = alu_carry;
               zf_next  = (alu_result == 8'h00);
            end else begin
               case (ir_op[1:0])
                  2'b01:   pc_next = target;
                  2'b10:   if (carry_flag) pc_next = target;
                  2'b11:   if (zero_flag) pc_next = target;
                  default: pc_next = pc;
               endcase
            end
         end
         OUT: begin
            if (out_ready) state_next = FETCH;
         end
         HALT: begin
            state_next = HALT;
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed programs plus random ROM images,
// checked against an instruction-level reference model with a behavioural ALU.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] pm_addr, pm_data, alu_a, alu_b, alu_result, out_data, acc;
   logic [2:0] alu_sel;
   logic       alu_carry, out_valid, out_ready, carry_flag, zero_flag, halted;

   logic [7:0] rom [256];
   int         total = 0;
   int         bad   = 0;
   int         valid_cycles;

   logic [7:0] m_pc, m_acc;
   logic       m_cf, m_zf, m_halted;

   // Behavioural ALU: 0 pass B, 1 add, 2 sub (carry = borrow), 3-5 logic, 6 shl, 7 shr.
   function automatic logic [8:0] alu_model(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
      case (sel)
         3'd0:    return {1'b0, b};
         3'd1:    return {1'b0, a} + {1'b0, b};
         3'd2:    return {(a < b), a - b};
         3'd3:    return {1'b0, a & b};
         3'd4:    return {1'b0, a | b};
         3'd5:    return {1'b0, a ^ b};
         3'd6:    return {a[7], a[6:0], 1'b0};
         default: return {a[0], 1'b0, a[7:1]};
      endcase
   endfunction

   always #5 clk = ~clk;
   always @(posedge clk) pm_data <= rom[pm_addr];
   assign {alu_carry, alu_result} = alu_model(alu_sel, alu_a, alu_b);

   alu_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .pm_addr(pm_addr), .pm_data(pm_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .acc(acc), .carry_flag(carry_flag), .zero_flag(zero_flag), .halted(halted)
   );

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check_output({tag, "_pc"}, 32'(pm_addr), 32'(m_pc));
      check_output({tag, "_acc"}, 32'(acc), 32'(m_acc));
      check_output({tag, "_cf"}, 32'(carry_flag), 32'(m_cf));
      check_output({tag, "_zf"}, 32'(zero_flag), 32'(m_zf));
      check_output({tag, "_halted"}, 32'(halted), 32'(m_halted));
      check_output({tag, "_valid"}, 32'(out_valid), 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset is raised between edges and checked before any clock edge can occur.
   task automatic apply_reset(input string tag);
      rst = 1'b1;
      #1;
      check_output({tag, "_pc"}, 32'(pm_addr), 32'h00);
      check_output({tag, "_acc"}, 32'(acc), 32'h00);
      check_output({tag, "_cf"}, 32'(carry_flag), 32'd0);
      check_output({tag, "_zf"}, 32'(zero_flag), 32'd0);
      check_output({tag, "_valid"}, 32'(out_valid), 32'd0);
      check_output({tag, "_halted"}, 32'(halted), 32'd0);
      m_pc = 8'h00; m_acc = 8'h00; m_cf = 1'b0; m_zf = 1'b0; m_halted = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic fill_rom(input logic [7:0] val);
      for (int i = 0; i < 256; i++) rom[i] = val;
   endtask

   // Executes one instruction in the model, clocks the DUT for its duration and compares.
   task automatic apply_stimulus(input int stall_req);
      logic [7:0] op, opnd, nxt;
      logic [8:0] r;
      int         stall, cycles;
      if (m_halted) begin
         tick();
         check_state("halt_hold");
         return;
      end
      nxt  = m_pc + 8'd1;
      op   = rom[m_pc];
      opnd = rom[nxt];
      stall = (stall_req < 0) ? int'($urandom_range(0, 3)) : stall_req;
      cycles = 3;
      if (!op[7]) begin
         r = alu_model(op[6:4], m_acc, opnd);
         m_acc = r[7:0];
         m_cf  = r[8];
         m_zf  = (r[7:0] == 8'h00);
         m_pc  = m_pc + 8'd2;
      end else begin
         case (op[7:4])
            4'h8: cycles = 0;
            4'h9: m_pc = opnd;
            4'hA: m_pc = m_cf ? opnd : m_pc + 8'd2;
            4'hB: m_pc = m_zf ? opnd : m_pc + 8'd2;
            4'hF: begin m_pc = nxt; m_halted = 1'b1; cycles = 2; end
            default: begin m_pc = nxt; cycles = 2; end
         endcase
      end
      if (op[7:4] == 4'h8) begin
         out_ready = 1'b0;
         tick();
         tick();
         valid_cycles = 0;
         for (int i = 0; i < stall; i++) begin
            check_output("out_wait_valid", 32'(out_valid), 32'd1);
            check_output("out_wait_data", 32'(out_data), 32'(m_acc));
            if (out_valid) valid_cycles++;
            tick();
         end
         check_output("out_accept_valid", 32'(out_valid), 32'd1);
         check_output("out_accept_data", 32'(out_data), 32'(m_acc));
         if (out_valid) valid_cycles++;
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         m_pc = nxt;
      end else begin
         repeat (cycles) tick();
      end
      check_state("instr");
   endtask

   initial begin
      out_ready = 1'b0;
      #2;

      // Two ALU ops, then reset asynchronously in the middle of the third.
      fill_rom(8'hF0);
      rom[0] = 8'h00; rom[1] = 8'hC8; rom[2] = 8'h10; rom[3] = 8'h64; rom[4] = 8'h10; rom[5] = 8'h01;
      apply_reset("rst_init");
      apply_stimulus(0);
      check_output("ld_acc", 32'(acc), 32'hC8);
      apply_stimulus(0);
      check_output("add_acc", 32'(acc), 32'h2C);
      check_output("add_cf", 32'(carry_flag), 32'd1);
      check_output("add_zf", 32'(zero_flag), 32'd0);
      tick();
      tick();
      #2;
      apply_reset("rst_mid_opnd");

      // Subtract to zero, then borrow.
      fill_rom(8'hF0);
      rom[0] = 8'h00; rom[1] = 8'h05; rom[2] = 8'h20; rom[3] = 8'h05; rom[4] = 8'h20; rom[5] = 8'h01;
      apply_reset("rst_sub");
      apply_stimulus(0);
      apply_stimulus(0);
      check_output("sub0_acc", 32'(acc), 32'h00);
      check_output("sub0_zf", 32'(zero_flag), 32'd1);
      check_output("sub0_cf", 32'(carry_flag), 32'd0);
      apply_stimulus(0);
      check_output("borrow_acc", 32'(acc), 32'hFF);
      check_output("borrow_cf", 32'(carry_flag), 32'd1);
      check_output("borrow_zf", 32'(zero_flag), 32'd0);

      // JZ taken, then JC not taken.
      fill_rom(8'hF0);
      rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'hB0; rom[3] = 8'h10; rom[16] = 8'hA0; rom[17] = 8'h20;
      apply_reset("rst_jmp");
      apply_stimulus(0);
      apply_stimulus(0);
      check_output("jz_taken_pc", 32'(pm_addr), 32'h10);
      apply_stimulus(0);
      check_output("jc_fall_pc", 32'(pm_addr), 32'h12);

      // OUT stalled for five cycles, then HLT freezes everything.
      fill_rom(8'hF0);
      rom[0] = 8'h00; rom[1] = 8'h2C; rom[2] = 8'h80; rom[3] = 8'hF0;
      apply_reset("rst_out");
      apply_stimulus(0);
      apply_stimulus(5);
      check_output("out_held_cycles", 32'(valid_cycles), 32'd6);
      apply_stimulus(0);
      check_output("hlt_halted", 32'(halted), 32'd1);
      repeat (3) apply_stimulus(0);
      check_output("hlt_pc_frozen", 32'(pm_addr), 32'h04);

      // Jump to the top address and wrap; then a 2-byte op at the top reads its operand from 0.
      fill_rom(8'hF0);
      rom[0] = 8'h90; rom[1] = 8'hFF; rom[255] = 8'hC0;
      apply_reset("rst_wrap");
      apply_stimulus(0);
      check_output("jmp_top_pc", 32'(pm_addr), 32'hFF);
      apply_stimulus(0);
      check_output("wrap_pc", 32'(pm_addr), 32'h00);
      rom[255] = 8'h00;
      apply_reset("rst_wrap2");
      apply_stimulus(0);
      apply_stimulus(0);
      check_output("top_opnd_acc", 32'(acc), 32'h90);
      check_output("top_opnd_pc", 32'(pm_addr), 32'h01);

      // Random ROM images against the reference model.
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
         apply_reset("rst_rand");
         for (int n = 0; n < 40; n++) apply_stimulus(-1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
